// File: rtl/ir_pkg.sv
// Shared types and helpers for the multi-byte instruction register.
// Optional feature macro used by this slice: IR_ILLEGAL_TRAP_EN.
package ir_pkg;

  // Sequencer states: await opcode, await operand bytes, instruction complete.
  typedef enum logic [1:0] {
    S_OPC  = 2'd0,
    S_OPD  = 2'd1,
    S_FULL = 2'd2
  } ir_state_t;

  // Width of one length-map entry (operand byte count per opcode).
  localparam int LEN_FIELD_W = 2;

  // Largest opcode field the lookup helper accepts, and the matching map size.
  localparam int OP_MAX_W  = 8;
  localparam int MAP_MAX_W = LEN_FIELD_W * (2 ** OP_MAX_W);

  // Raw operand byte count for an opcode; callers zero-extend their map and opcode.
  function automatic logic [LEN_FIELD_W-1:0] opd_len(input logic [MAP_MAX_W-1:0] map,
                                                     input logic [OP_MAX_W-1:0]  op);
    return map[LEN_FIELD_W*int'(op) +: LEN_FIELD_W];
  endfunction

endpackage

// File: rtl/ir_len_dec.sv
// Combinational length-map lookup for one opcode.
// Entries larger than MAX_OPD are clamped to MAX_OPD in the default build; with
// IR_ILLEGAL_TRAP_EN defined they are reported on 'over' and decoded as length 0.
module ir_len_dec
  import ir_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int MAX_OPD = 2,
  parameter logic [LEN_FIELD_W*(2**OP_W)-1:0] LEN_MAP = '0
) (
  input  logic [OP_W-1:0]        op,
  output logic [LEN_FIELD_W-1:0] len
`ifdef IR_ILLEGAL_TRAP_EN
  ,
  output logic                   over
`endif
);

  localparam logic [MAP_MAX_W-1:0] MAP_EXT = MAP_MAX_W'(LEN_MAP);

  logic [LEN_FIELD_W-1:0] raw;

  // Look up the entry and fold out-of-range lengths into a legal value.
  always_comb begin
    raw = opd_len(MAP_EXT, OP_MAX_W'(op));
`ifdef IR_ILLEGAL_TRAP_EN
    over = (int'(raw) > MAX_OPD);
    len  = over ? '0 : raw;
`else
    len  = (int'(raw) > MAX_OPD) ? LEN_FIELD_W'(MAX_OPD) : raw;
`endif
  end

endmodule

// File: rtl/ir_seq.sv
// Multi-byte instruction register: opcode byte followed by 0..MAX_OPD operand
// bytes, assembled little-endian into the operand register driven onto ABUS.
// Optional feature macro: IR_ILLEGAL_TRAP_EN (adds the sticky 'illegal' output).
module ir_seq
  import ir_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int OP_W        = 4,
  parameter int ADDR_W      = 8,
  parameter int MAX_OPD     = 2,
  parameter logic [LEN_FIELD_W*(2**OP_W)-1:0] LEN_MAP = '0,
  parameter int INLINE_ADDR = 1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              nLi,
  input  logic              nEi,
  input  logic [DATA_W-1:0] DBUS,
  inout  wire logic [ADDR_W-1:0] ABUS,
  output logic [OP_W-1:0]   opcode,
  output logic              ir_rdy,
  output logic [1:0]        opd_idx
`ifdef IR_ILLEGAL_TRAP_EN
  ,
  output logic              illegal
`endif
);

  // Width of the inline address field below the opcode.
  localparam int INL_W = DATA_W - OP_W;

  ir_state_t              state_q, state_d;
  logic [OP_W-1:0]        opcode_q, opcode_d;
  logic [ADDR_W-1:0]      operand_q, operand_d;
  logic [1:0]             idx_q, idx_d;
  logic [1:0]             rem_q, rem_d;
  logic [OP_W-1:0]        op_in;
  logic [LEN_FIELD_W-1:0] len;
`ifdef IR_ILLEGAL_TRAP_EN
  logic                   over;
  logic                   illegal_q, illegal_d;
`endif

  assign op_in = DBUS[DATA_W-1 -: OP_W];

  ir_len_dec #(
    .OP_W    (OP_W),
    .MAX_OPD (MAX_OPD),
    .LEN_MAP (LEN_MAP)
  ) u_len_dec (
    .op  (op_in),
    .len (len)
`ifdef IR_ILLEGAL_TRAP_EN
    ,
    .over(over)
`endif
  );

  // Next-state and register-update decode; every load strobe acts on the current state.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
`ifdef IR_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    if (!nLi) begin
      case (state_q)
        S_OPC, S_FULL: begin
          // A load here always starts a new instruction, even straight out of S_FULL.
          opcode_d = op_in;
          idx_d    = '0;
`ifdef IR_ILLEGAL_TRAP_EN
          illegal_d = illegal_q | over;
`endif
          if (len == '0) begin
            for (int b = 0; b < ADDR_W; b++) begin
              operand_d[b] = (INLINE_ADDR != 0) && (b < INL_W) ? DBUS[b % DATA_W] : 1'b0;
            end
            rem_d   = '0;
            state_d = S_FULL;
          end else begin
            operand_d = '0;
            rem_d     = len;
            state_d   = S_OPD;
          end
        end
        S_OPD: begin
          // Byte lane idx_q receives DBUS; lanes past ADDR_W simply have no bits.
          for (int b = 0; b < ADDR_W; b++) begin
            if (b / DATA_W == int'(idx_q)) operand_d[b] = DBUS[b % DATA_W];
          end
          if (idx_q == rem_q - 2'd1) begin
            idx_d   = '0;
            state_d = S_FULL;
          end else begin
            idx_d   = idx_q + 2'd1;
          end
        end
        default: begin
          state_d = S_OPC;
        end
      endcase
    end
  end

  // State and datapath registers; CLR aborts any partial instruction immediately.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q   <= S_OPC;
      opcode_q  <= '0;
      operand_q <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
`ifdef IR_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
`ifdef IR_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign opcode  = opcode_q;
  assign ir_rdy  = (state_q == S_FULL);
  assign opd_idx = idx_q;
`ifdef IR_ILLEGAL_TRAP_EN
  assign illegal = illegal_q;
`endif

  // Operand bus is released whenever the output enable is inactive.
  assign ABUS = nEi ? {ADDR_W{1'bz}} : operand_q;

endmodule
